// File: rtl/ez8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ez8_ctrl_pkg
//  Purpose  : Shared state encoding and PC source-select constants for
//             exec_ctrl. INT state exists only when EZ8_INTERRUPT_EN is set.
//  Revision : 1.0  initial release
// ============================================================================
package ez8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_WB   = 3'd2,
`ifdef EZ8_INTERRUPT_EN
        ST_SKIP = 3'd3,
        ST_INT  = 3'd4
`else
        ST_SKIP = 3'd3
`endif
    } state_t;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_HOLD   = 2'd1;
    localparam logic [1:0] PC_VECTOR = 2'd2;
    localparam logic [1:0] PC_RETURN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : exec_ctrl
//  Purpose  : Execute/write-back/skip/interrupt sequencing controller.
//             Interrupt support is built only when EZ8_INTERRUPT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module exec_ctrl
    import ez8_ctrl_pkg::*;
#(
    parameter int PC_SEL_W = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                alu_accum_write,
    input  logic                alu_reg_write,
    input  logic                alu_z_write,
    input  logic                alu_c_write,
    input  logic                alu_retint,
    input  logic                alu_skip,
    input  logic                alu_zout,
    input  logic                alu_cout,
    input  logic                rf_busy,
    input  logic                intr_req,
    input  logic                ie_set,
    output logic                accum_we,
    output logic                reg_we,
    output logic                z_flag,
    output logic                c_flag,
    output logic                ie,
    output logic                int_ack,
    output logic [PC_SEL_W-1:0] pc_sel
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_z;
    logic       r_c;
    logic       r_skip;
    logic [1:0] w_pc_sel;
    logic       w_int_ack;

`ifdef EZ8_INTERRUPT_EN
    logic       r_ie;
`else
    logic       w_unused;
    assign w_unused = intr_req | ie_set;
`endif

    // Outputs decode from state plus live ALU/handshake inputs; a held reset
    // forces every output to its idle-safe value.
    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        accum_we    = 1'b0;
        reg_we      = 1'b0;
        w_int_ack   = 1'b0;
        w_pc_sel    = PC_HOLD;
        if (reset_n) begin
            case (r_state)
                ST_IDLE: begin
`ifdef EZ8_INTERRUPT_EN
                    if (intr_req && r_ie) begin
                        w_state_nxt = ST_INT;
                    end else
`endif
                    begin
                        instr_ready = 1'b1;
                        if (instr_valid) begin
                            w_pc_sel    = PC_INC;
                            w_state_nxt = ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    accum_we = alu_accum_write;
                    if (alu_retint) begin
                        w_pc_sel = PC_RETURN;
                    end
                    if (alu_reg_write) begin
                        w_state_nxt = ST_WB;
                    end else if (alu_skip) begin
                        w_state_nxt = ST_SKIP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WB: begin
                    reg_we = !rf_busy;
                    if (!rf_busy) begin
                        w_state_nxt = r_skip ? ST_SKIP : ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    // The accepted instruction is dropped: no enables, no flags.
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        w_pc_sel    = PC_INC;
                        w_state_nxt = ST_IDLE;
                    end
                end
`ifdef EZ8_INTERRUPT_EN
                ST_INT: begin
                    w_int_ack   = 1'b1;
                    w_pc_sel    = PC_VECTOR;
                    w_state_nxt = ST_IDLE;
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_skip  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_EXEC) begin
                if (alu_z_write) begin
                    r_z <= alu_zout;
                end
                if (alu_c_write) begin
                    r_c <= alu_cout;
                end
                r_skip <= alu_skip;
            end else if (r_state == ST_WB && !rf_busy) begin
                r_skip <= 1'b0;
            end
        end
    end

`ifdef EZ8_INTERRUPT_EN
    // Taking an interrupt clears enable even if ie_set arrives the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ie <= 1'b0;
        end else if (r_state == ST_INT) begin
            r_ie <= 1'b0;
        end else if ((r_state == ST_EXEC && alu_retint) || ie_set) begin
            r_ie <= 1'b1;
        end
    end

    assign ie      = r_ie;
    assign int_ack = w_int_ack;
`else
    assign ie      = 1'b0;
    assign int_ack = 1'b0;
`endif

    assign z_flag = r_z;
    assign c_flag = r_c;
    assign pc_sel = PC_SEL_W'(w_pc_sel);

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_ctrl
//  Purpose  : Directed self-checking bench for exec_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exec_ctrl;

    logic       clk;
    logic       reset_n;
    logic       instr_valid;
    logic       instr_ready;
    logic       alu_accum_write;
    logic       alu_reg_write;
    logic       alu_z_write;
    logic       alu_c_write;
    logic       alu_retint;
    logic       alu_skip;
    logic       alu_zout;
    logic       alu_cout;
    logic       rf_busy;
    logic       intr_req;
    logic       ie_set;
    logic       accum_we;
    logic       reg_we;
    logic       z_flag;
    logic       c_flag;
    logic       ie;
    logic       int_ack;
    logic [1:0] pc_sel;

    int total = 0;
    int bad   = 0;

    exec_ctrl #(.PC_SEL_W(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .alu_accum_write (alu_accum_write),
        .alu_reg_write   (alu_reg_write),
        .alu_z_write     (alu_z_write),
        .alu_c_write     (alu_c_write),
        .alu_retint      (alu_retint),
        .alu_skip        (alu_skip),
        .alu_zout        (alu_zout),
        .alu_cout        (alu_cout),
        .rf_busy         (rf_busy),
        .intr_req        (intr_req),
        .ie_set          (ie_set),
        .accum_we        (accum_we),
        .reg_we          (reg_we),
        .z_flag          (z_flag),
        .c_flag          (c_flag),
        .ie              (ie),
        .int_ack         (int_ack),
        .pc_sel          (pc_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_alu();
        alu_accum_write = 1'b0;
        alu_reg_write   = 1'b0;
        alu_z_write     = 1'b0;
        alu_c_write     = 1'b0;
        alu_retint      = 1'b0;
        alu_skip        = 1'b0;
        alu_zout        = 1'b0;
        alu_cout        = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; instr_valid = 1'b0; rf_busy = 1'b0;
        intr_req = 1'b0; ie_set = 1'b0;
        clr_alu();
        #1;
        chk("rst_ready", instr_ready, 0);
        chk("rst_pcsel", pc_sel, 1);
        chk("rst_enables", {accum_we, reg_we, int_ack}, 0);
        step();
        chk("rst_flags", {z_flag, c_flag, ie}, 0);
        reset_n = 1'b1;
        #1;
        chk("idle_ready", instr_ready, 1);
        chk("idle_pcsel", pc_sel, 1);

        // Add: accumulator write with both flags set
        instr_valid = 1'b1; #1;
        chk("idle_hs_pcsel", pc_sel, 0);
        step();
        instr_valid = 1'b0;
        alu_accum_write = 1'b1; alu_z_write = 1'b1; alu_c_write = 1'b1;
        alu_zout = 1'b1; alu_cout = 1'b1; #1;
        chk("add_accum_we", accum_we, 1);
        chk("add_exec_misc", {instr_ready, reg_we}, 0);
        chk("add_exec_pcsel", pc_sel, 1);
        step();
        clr_alu(); #1;
        chk("add_flags", {z_flag, c_flag}, 3);
        chk("add_back_idle", {instr_ready, accum_we}, 2);

        // Only Z written: C must hold
        instr_valid = 1'b1; step();
        instr_valid = 1'b0; alu_z_write = 1'b1; alu_cout = 1'b0; step();
        clr_alu(); #1;
        chk("zonly_flags", {z_flag, c_flag}, 1);

        // Register write stalled by rf_busy for 3 cycles
        instr_valid = 1'b1; step();
        instr_valid = 1'b0; alu_reg_write = 1'b1; rf_busy = 1'b1; #1;
        chk("rw_exec_we", {accum_we, reg_we}, 0);
        step();
        clr_alu();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rw_busy_we", {instr_ready, reg_we}, 0);
            step();
        end
        rf_busy = 1'b0; #1;
        chk("rw_write", reg_we, 1);
        step();
        chk("rw_done", {instr_ready, reg_we}, 2);

        // Skip carried through WB; following instruction discarded
        instr_valid = 1'b1; step();
        instr_valid = 1'b0; alu_reg_write = 1'b1; alu_skip = 1'b1; step();
        clr_alu(); #1;
        chk("skwb_write", reg_we, 1);
        step();
        chk("skip_ready", {instr_ready, pc_sel}, 4'b0101);
        instr_valid = 1'b1; alu_accum_write = 1'b1; alu_c_write = 1'b1; alu_cout = 1'b0; #1;
        chk("skip_hs_pcsel", pc_sel, 0);
        chk("skip_hs_en", {accum_we, reg_we}, 0);
        step();
        instr_valid = 1'b0; clr_alu(); #1;
        chk("skip_flags_kept", {z_flag, c_flag}, 1);
        chk("skip_to_idle", {instr_ready, pc_sel}, 4'b0101);

        // Skip without register write goes straight to SKIP
        instr_valid = 1'b1; step();
        instr_valid = 1'b0; alu_skip = 1'b1; step();
        clr_alu(); instr_valid = 1'b1; step();
        instr_valid = 1'b0; alu_accum_write = 1'b1; #1;
        chk("skip_direct_drop", accum_we, 0);
        clr_alu(); step();

        // Reset in the middle of a stalled write-back
        instr_valid = 1'b1; step();
        instr_valid = 1'b0; alu_reg_write = 1'b1; alu_z_write = 1'b1; alu_zout = 1'b1;
        rf_busy = 1'b1; step();
        clr_alu(); reset_n = 1'b0; #1;
        chk("rstwb_outputs", {instr_ready, reg_we}, 0);
        step();
        reset_n = 1'b1; rf_busy = 1'b0; #1;
        chk("rstwb_idle", {instr_ready, reg_we}, 2);
        chk("rstwb_flags", {z_flag, c_flag}, 0);

`ifdef EZ8_INTERRUPT_EN
        ie_set = 1'b1; step();
        ie_set = 1'b0; #1;
        chk("int_ie_set", ie, 1);
        intr_req = 1'b1; instr_valid = 1'b1; #1;
        chk("int_idle_block", {instr_ready, pc_sel}, 4'b0001);
        step();
        instr_valid = 1'b0; ie_set = 1'b1; #1;
        chk("int_ack", {int_ack, instr_ready}, 2);
        chk("int_pcsel", pc_sel, 2);
        step();
        ie_set = 1'b0; #1;
        chk("int_ie_clr", {ie, int_ack}, 0);
        chk("int_masked", instr_ready, 1);
        instr_valid = 1'b1; step();
        instr_valid = 1'b0; alu_retint = 1'b1; #1;
        chk("reti_pcsel", pc_sel, 3);
        step();
        clr_alu(); intr_req = 1'b0; #1;
        chk("reti_ie", ie, 1);
`else
        intr_req = 1'b1; ie_set = 1'b1; step();
        ie_set = 1'b0; #1;
        chk("noint_ie", {ie, int_ack}, 0);
        chk("noint_ready", instr_ready, 1);
        instr_valid = 1'b1; #1;
        chk("noint_hs_pcsel", pc_sel, 0);
        step();
        instr_valid = 1'b0; alu_retint = 1'b1; #1;
        chk("noint_reti_pcsel", pc_sel, 3);
        step();
        clr_alu(); #1;
        chk("noint_reti_ie", {ie, int_ack, instr_ready}, 1);
        intr_req = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter: PC_SEL_W, default 2, width of pc_sel; fixed encoding 0=inc, 1=hold, 2=vector, 3=return.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset_n  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 instr_valid  in  1  fetch stage presents an instruction.
REQ-005 instr_ready  out  1  controller accepts instruction; transfer on instr_valid && instr_ready.
REQ-006 alu_accum_write, alu_reg_write, alu_z_write, alu_c_write, alu_retint, alu_skip  in  1 each  ALU decode/result strobes, valid in EXEC.
REQ-007 alu_zout, alu_cout  in  1 each  ALU flag results.
REQ-008 rf_busy  in  1  register-file write port busy.
REQ-009 intr_req  in  1  level interrupt request.
REQ-010 ie_set  in  1  one-cycle pulse setting interrupt enable.
REQ-011 accum_we, reg_we  out  1 each  write enables.
REQ-012 z_flag, c_flag, ie  out  1 each  architectural status bits.
REQ-013 int_ack  out  1  one-cycle interrupt acknowledge.
REQ-014 pc_sel  out  PC_SEL_W  program-counter source select.

Function
REQ-015 FSM states: IDLE, EXEC, WB, SKIP, INT; registered state, Moore outputs except where stated.
REQ-016 IDLE: instr_ready=1, pc_sel=hold; if intr_req && ie, instr_ready=0 and next=INT (interrupt wins over a valid instruction); else handshake -> EXEC, pc_sel=inc that cycle.
REQ-017 EXEC (exactly 1 cycle): accum_we=alu_accum_write; z_flag<=alu_zout if alu_z_write; c_flag<=alu_cout if alu_c_write; alu_retint -> pc_sel=return, ie<=1.
REQ-018 EXEC next: alu_reg_write -> WB; else alu_skip -> SKIP; else IDLE; skip value captured in EXEC is carried through WB.
REQ-019 WB: reg_we=!rf_busy; stays while rf_busy=1; on rf_busy=0 writes one cycle, then SKIP if captured skip else IDLE.
REQ-020 SKIP: instr_ready=1; next handshaked instruction discarded (no enables, flags unchanged), pc_sel=inc, -> IDLE; interrupts not taken in SKIP.
REQ-021 INT (1 cycle): int_ack=1, pc_sel=vector, ie<=0, -> IDLE.
REQ-022 ie_set coincident with INT: clear wins; coincident with retint: ie=1.
REQ-023 reg_we and accum_we never both 1 in one cycle; outputs not listed for a state are 0.

Reset
REQ-024 reset_n=0 at clk edge: state=IDLE, z_flag=0, c_flag=0, ie=0, captured skip=0; reset dominates all inputs, including mid-WB and mid-SKIP (pending write/skip dropped).
REQ-025 During reset cycle outputs: instr_ready=0, pc_sel=hold, all enables/int_ack 0.

Configuration
REQ-026 Macro EZ8_INTERRUPT_EN: defined -> INT state, ie, int_ack behave as above.
REQ-027 Undefined -> INT state absent, intr_req and ie_set ignored, ie and int_ack tied 0, alu_retint behaves as plain return (pc_sel=return, no ie change).

Structure
REQ-028 Shared package ez8_ctrl_pkg holds state enum and pc_sel encoding constants (PC_INC, PC_HOLD, PC_VECTOR, PC_RETURN).
REQ-029 Single module; no sub-module (flag/ie registers are inline).

Verification
REQ-030 Reset mid-WB with rf_busy=1 -> next cycle state IDLE, reg_we=0, flags 0.
REQ-031 Add (accum_write, z_write, c_write, zout=1, cout=1) -> accum_we pulse 1 cycle in EXEC, z_flag=1, c_flag=1, back to IDLE after 1 cycle.
REQ-032 reg_write with rf_busy high 3 cycles -> reg_we low 3 cycles, high exactly 1, then IDLE.
REQ-033 alu_skip=1 with reg_write=1 -> WB, then SKIP; following instruction accepted with no enables, pc_sel=inc.
REQ-034 ie=1, intr_req and instr_valid together in IDLE -> instr_ready=0, INT next: int_ack=1, pc_sel=2, ie=0; retint later -> pc_sel=3, ie=1.
REQ-035 Macro undefined, intr_req=1, ie_set pulsed -> int_ack never asserted, ie stays 0.
